// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the program-run controller.
//   run_state_t : controller FSM states
//   prog_id_t   : program select code (0 = invalid, 1..3 = programs)
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  typedef logic [1:0] prog_id_t;

  localparam prog_id_t PROG_MUL  = 2'd1;
  localparam prog_id_t PROG_STR  = 2'd2;
  localparam prog_id_t PROG_PAIR = 2'd3;

endpackage

// File: rtl/prog_run_ctrl_if.sv
// Start/done run handshake between an external requester and the run
// controller.
//   start, prog_sel, abort              : requester -> controller
//   busy, done, timeout, cycle_count    : controller -> requester
// master = requester side, slave = controller side.
interface prog_run_ctrl_if #(
  parameter int CNT_W = 16
) ();
  import run_ctrl_pkg::*;

  logic             start;
  prog_id_t         prog_sel;
  logic             abort;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start, prog_sel, abort,
    input  busy, done, timeout, cycle_count
  );

  modport slave (
    input  start, prog_sel, abort,
    output busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/prog_pc_table.sv
// Combinational program table: maps a program select code to its start PC.
//   prog_sel : program code (1..3 valid)
//   pc       : start PC of the selected program
//   valid    : 1 when prog_sel names a real program
module prog_pc_table
  import run_ctrl_pkg::*;
#(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] PROG1_PC = '0,
  parameter logic [PC_W-1:0] PROG2_PC = '0,
  parameter logic [PC_W-1:0] PROG3_PC = '0
) (
  input  prog_id_t        prog_sel,
  output logic [PC_W-1:0] pc,
  output logic            valid
);

  always_comb begin
    pc    = PROG1_PC;
    valid = 1'b0;
    case (prog_sel)
      PROG_MUL:  begin pc = PROG1_PC; valid = 1'b1; end
      PROG_STR:  begin pc = PROG2_PC; valid = 1'b1; end
      PROG_PAIR: begin pc = PROG3_PC; valid = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/prog_run_ctrl.sv
// Program run controller. Accepts a start request, holds the core in reset
// for RST_CYCLES cycles while loading the program start PC, then lets the
// core run and counts cycles until it halts, a watchdog expires, or the run
// is aborted.
//   clk, reset  : clock, asynchronous active-low reset
//   rif         : run handshake (start/prog_sel/abort in; busy/done/
//                 timeout/cycle_count out)
//   core_halt   : core has reached its halt instruction (level)
//   core_rst    : active-high reset to the core
//   pc_load     : one-cycle pulse, core loads start_pc
//   start_pc    : start PC of the selected program
module prog_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int              PC_W       = 10,
  parameter int              CNT_W      = 16,
  parameter int              RST_CYCLES = 2,
  parameter int unsigned     TIMEOUT    = 4000,
  parameter logic [PC_W-1:0] PROG1_PC   = '0,
  parameter logic [PC_W-1:0] PROG2_PC   = '0,
  parameter logic [PC_W-1:0] PROG3_PC   = '0
) (
  input  logic            clk,
  input  logic            reset,
  prog_run_ctrl_if.slave  rif,
  input  logic            core_halt,
  output logic            core_rst,
  output logic            pc_load,
  output logic [PC_W-1:0] start_pc
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);

  run_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic [PC_W-1:0]   start_pc_q, start_pc_d;
  logic              timeout_q, timeout_d;
  logic              pc_load_q, pc_load_d;
  logic              core_rst_q, core_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [PC_W-1:0]   table_pc;
  logic              table_valid;

  prog_pc_table #(
    .PC_W     (PC_W),
    .PROG1_PC (PROG1_PC),
    .PROG2_PC (PROG2_PC),
    .PROG3_PC (PROG3_PC)
  ) u_pc_table (
    .prog_sel (rif.prog_sel),
    .pc       (table_pc),
    .valid    (table_valid)
  );

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    start_pc_d  = start_pc_q;
    timeout_d   = timeout_q;
    pc_load_d   = 1'b0;

    case (state_q)
      // Start is only honoured while idle or finished; abort has no
      // meaning here, so a simultaneous start always wins.
      IDLE, DONE: begin
        if (rif.start && table_valid) begin
          state_d     = HOLD;
          hold_cnt_d  = '0;
          cycle_cnt_d = '0;
          timeout_d   = 1'b0;
          start_pc_d  = table_pc;
          pc_load_d   = (hold_cnt_d == HOLD_LAST);
        end
      end

      HOLD: begin
        if (rif.abort) begin
          state_d = IDLE;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          // Registered pulse lands on the last HOLD cycle.
          pc_load_d  = (hold_cnt_d == HOLD_LAST);
        end
      end

      RUN: begin
        if (rif.abort) begin
          state_d   = IDLE;
          timeout_d = 1'b0;
        end else if (core_halt) begin
          // Halt beats the watchdog; count is frozen at the halt cycle.
          state_d = DONE;
        end else if (cycle_cnt_q == CNT_LAST) begin
          state_d     = DONE;
          timeout_d   = 1'b1;
          cycle_cnt_d = CNT_MAX;
        end else begin
          cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Core is held in reset everywhere except RUN, including DONE so its
    // memory stays frozen for readback.
    core_rst_d = (state_d != RUN);
    busy_d     = (state_d == HOLD) || (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      start_pc_q  <= PROG1_PC;
      timeout_q   <= 1'b0;
      pc_load_q   <= 1'b0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      start_pc_q  <= start_pc_d;
      timeout_q   <= timeout_d;
      pc_load_q   <= pc_load_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign core_rst        = core_rst_q;
  assign pc_load         = pc_load_q;
  assign start_pc        = start_pc_q;
  assign rif.busy        = busy_q;
  assign rif.done        = done_q;
  assign rif.timeout     = timeout_q;
  assign rif.cycle_count = cycle_cnt_q;

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
On-chip run controller for the core: the responder side of the start/done program-run handshake. It accepts a start request with a program select, holds the core in reset for a fixed number of cycles, and loads the program's start PC. It then releases the core, counts execution cycles, and reports completion when the core halts or a watchdog expires. It sits between the external run interface and the core's reset/PC-load inputs.

Parameters:
PC_W, 10, width of start PC
CNT_W, 16, width of cycle counter
RST_CYCLES, 2, cycles core_rst is held after an accepted start (>=1)
TIMEOUT, 16'd4000, run-cycle limit before forced completion (>=1, < 2**CNT_W)
PROG1_PC, 0, start PC for program 1 (multiply)
PROG2_PC, 0, start PC for program 2 (pattern search)
PROG3_PC, 0, start PC for program 3 (closest pair)

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  run request, sampled in IDLE/DONE only
prog_sel  in  2  program number 1..3; 0 = invalid
abort  in  1  synchronous abort of a run in progress
core_halt  in  1  core has executed its halt instruction (level)
core_rst  out  1  synchronous active-high reset to core
pc_load  out  1  one-cycle pulse: core loads start_pc
start_pc  out  PC_W  latched start PC of selected program
busy  out  1  run in progress (HOLD or RUN)
done  out  1  run finished; level until next accepted start or reset
timeout  out  1  last run ended by watchdog; valid while done=1
cycle_count  out  CNT_W  cycles spent in RUN during the last/current run

Behaviour:
- Reset (reset=0, async): state=IDLE, core_rst=1, pc_load=0, start_pc=PROG1_PC, busy=0, done=0, timeout=0, cycle_count=0, hold counter=0.
- States: IDLE, HOLD, RUN, DONE. All outputs registered.
- IDLE: start=1 and prog_sel in 1..3 -> next cycle HOLD; start_pc latched from table, cycle_count=0, timeout=0, busy=1, core_rst=1. start with prog_sel=0 is ignored; state stays IDLE.
- HOLD: core_rst=1 for exactly RST_CYCLES cycles. pc_load=1 during the last HOLD cycle. Then RUN; core_rst=0 from the first RUN cycle. core_halt is ignored in HOLD.
- RUN: cycle_count increments by 1 each cycle. core_halt=1 -> DONE next cycle, and cycle_count holds the value of the halt cycle (not incremented on that cycle). If cycle_count==TIMEOUT-1 while core_halt=0 -> DONE with timeout=1 and cycle_count=TIMEOUT. core_halt and timeout in the same cycle: halt wins, timeout=0.
- DONE: done=1, busy=0, core_rst=1 (core frozen so the bench can read memory), cycle_count and timeout held. A valid start -> HOLD with done cleared the same edge (back-to-back runs without a global reset). Invalid start -> stay in DONE.
- start in HOLD/RUN: ignored, no queuing.
- abort=1 in HOLD/RUN -> IDLE next cycle: core_rst=1, busy=0, done=0, timeout=0, cycle_count held. abort in IDLE/DONE: no effect. abort and start in the same cycle in DONE: abort is ignored and start is taken.
- Async reset mid-run: immediate return to reset values; no done pulse.
- cycle_count never wraps; it is bounded by TIMEOUT.

Decomposition:
- Package run_ctrl_pkg: enum run_state_t {IDLE,HOLD,RUN,DONE}; typedef prog_id_t logic[1:0]; constants PROG_MUL=1, PROG_STR=2, PROG_PAIR=3.
- One sub-module: prog_pc_table, a combinational map from prog_sel to start PC plus a valid flag, parameterised by PROG*_PC. FSM and counters stay in the top module.

Test Plan:
- reset=0 then 1, no start -> core_rst=1, busy=0, done=0, cycle_count=0 held for 20 cycles.
- RST_CYCLES=2, PROG2_PC=10'h040, start=1/prog_sel=2 at cycle 0, core_halt at 37th RUN cycle -> core_rst high 2 cycles, pc_load 1 cycle with start_pc=0x040, done=1, cycle_count=36, timeout=0.
- TIMEOUT=1000, core_halt never asserted -> done=1 after 1000 RUN cycles, timeout=1, cycle_count=1000.
- Sequence of runs prog 1, 2, 3 via start in DONE -> each run's start_pc matches its table entry; done falls on each accept and rises at each halt.
- start with prog_sel=0 in IDLE; start pulse during RUN -> both ignored, state and cycle_count unaffected.
- abort at RUN cycle 5 -> IDLE, core_rst=1, done=0; reset=0 mid-RUN -> all outputs at reset values asynchronously.
